// File: rtl/btn_cond_if.sv
// Button bus between the raw pads and the conditioner: raw levels in, debounced levels and press pulses out.
interface btn_cond_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse
    );
endinterface

// File: rtl/btn_cond.sv
// Five-button conditioner: two-flop synchronizer, per-bit debounce and one-cycle press pulses.
// Optional per-bit auto-repeat when BTN_COND_AUTOREPEAT_EN is defined.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    btn_cond_if.slave btn
);
    localparam int NB = 5;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_TC = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_bad_param
        $error("btn_cond: timing parameters must lie in 2..65535");
    end

    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] level_q, level_d;
    logic [NB-1:0] pulse_q, pulse_d;
    logic [NB-1:0] rise;
    logic [NB-1:0] rpt_fire;
    logic [DW-1:0] dcnt_q [NB];
    logic [DW-1:0] dcnt_d [NB];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts.
    always_comb begin
        sync1_d = btn.btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise    = '0;
        for (int i = 0; i < NB; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == DCNT_TC) begin
                    level_d[i] = sync2_q[i];
                    rise[i]    = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
        pulse_d = rise | rpt_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < NB; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NB; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam logic [15:0] RPT_DLY_LD = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_PER_LD = 16'(REPEAT_PERIOD - 1);

    logic [15:0]   rcnt_q [NB];
    logic [15:0]   rcnt_d [NB];
    logic [NB-1:0] fall;

    // Down-counter reloads on each pulse; a release landing on terminal count must not fire.
    always_comb begin
        fall     = level_q & ~level_d;
        rpt_fire = '0;
        for (int i = 0; i < NB; i++) begin
            rcnt_d[i] = rcnt_q[i];
            if (rise[i]) begin
                rcnt_d[i] = RPT_DLY_LD;
            end else if (!level_q[i] || fall[i]) begin
                rcnt_d[i] = '0;
            end else if (rcnt_q[i] == 16'd0) begin
                rpt_fire[i] = 1'b1;
                rcnt_d[i]   = RPT_PER_LD;
            end else begin
                rcnt_d[i] = rcnt_q[i] - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    assign btn.btn_level = level_q;
    assign btn.btn_pulse = pulse_q;
endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20: consecutive cycles a synchronized input must differ from its debounced level before the level changes (legal range 2..65535).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 1000: cycles from a press pulse to the first auto-repeat pulse (legal range 2..65535).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 200: cycles between later auto-repeat pulses (legal range 2..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port btn_raw, input, 5 bits: raw, asynchronous button inputs, ordered {btnd, btnr, btnu, btnl, btnc}.
REQ-007 The block SHALL have port btn_level, output, 5 bits: debounced, registered button levels, same bit order as btn_raw.
REQ-008 The block SHALL have port btn_pulse, output, 5 bits: registered pulses, one cycle wide, on press (and on repeat, see Configuration); this port drives the calculator button inputs.

Function
REQ-009 Each bit SHALL be processed independently by identical per-bit logic, with no shared counters.
REQ-010 Each btn_raw bit SHALL pass through a two-flop synchronizer; only the second flop output (sync) feeds later logic.
REQ-011 Each bit SHALL have a debounce counter sized to hold DEBOUNCE_CYCLES-1.
  - Counter clears to 0 on any cycle where sync equals btn_level.
  - Counter increments on each cycle where sync differs from btn_level.
REQ-012 btn_level SHALL take the value of sync on the edge where sync differs and the counter equals DEBOUNCE_CYCLES-1; the counter clears on that same edge.
REQ-013 Any glitch shorter than DEBOUNCE_CYCLES consecutive sampled cycles SHALL leave btn_level unchanged, and the counter SHALL restart from 0.
REQ-014 Latency from a stable raw edge to btn_level changing SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-015 btn_pulse[i] SHALL be 1 for exactly the one cycle that follows the edge where btn_level[i] goes 0->1; it SHALL be registered and asserted in the same cycle btn_level[i] first reads 1.
REQ-016 A 1->0 transition of btn_level SHALL produce no pulse.
REQ-017 Simultaneous presses on several bits SHALL produce simultaneous pulses; the block SHALL NOT arbitrate or mask between buttons.
REQ-018 btn_pulse SHALL never be high for two consecutive cycles on the same bit.

Reset
REQ-019 While rst_n=0, the synchronizer flops, debounce counters, repeat counters, btn_level and btn_pulse SHALL all be 0, asynchronously.
REQ-020 After rst_n rises, the first btn_level change SHALL require the full 2 + DEBOUNCE_CYCLES cycles, even if the button was held through reset.
REQ-021 A button held through reset SHALL therefore produce exactly one press pulse after reset is released.
REQ-022 Asserting reset mid-debounce or mid-repeat SHALL abandon the operation with no pulse emitted.

Configuration
REQ-023 With macro BTN_COND_AUTOREPEAT_EN defined, each bit SHALL have a repeat counter that clears on the press pulse and counts while btn_level=1.
  - First extra pulse: REPEAT_DELAY cycles after the press pulse.
  - Further pulses: every REPEAT_PERIOD cycles after that, while btn_level stays 1.
  - btn_level falling clears the counter in the same cycle; no pulse is emitted on release.
REQ-024 With BTN_COND_AUTOREPEAT_EN undefined, no repeat counters SHALL exist, and exactly one pulse SHALL be emitted per press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-025 Clean press: btn_raw[0] 0->1 at cycle 0, held -> btn_level[0]=1 from cycle 6; btn_pulse[0]=1 in cycle 6 only; other bits stay 0.
REQ-026 Glitch reject: btn_raw[3] high for 3 cycles then low -> btn_level and btn_pulse stay 0; a following 4+ cycle high is still accepted.
REQ-027 Bounce: btn_raw[2] toggles 1,0,1,0,1 then holds 1 -> exactly one pulse, 6 cycles after the final rising edge.
REQ-028 Simultaneous press: btn_raw=5'b10001 at cycle 0 -> btn_pulse=5'b10001 in cycle 6 only.
REQ-029 Reset mid-operation: btn_raw[1] held, rst_n=0 at cycle 4 for 2 cycles -> no pulse during reset; one pulse 6 cycles after rst_n rises.
REQ-030 Autorepeat (macro defined): btn_raw[4] held for 40 cycles -> pulses at cycles 6, 16, 21, 26, 31, 36, 41, with none after release settles; with the macro undefined -> a single pulse at cycle 6.
